// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit between the EX stage and a single-beat data bus.
// A non-memory op writes back one cycle after EX. A memory op is captured,
// issued on the bus, and held until ack. The writeback registers are then
// loaded with the extended load data; a store writes back nothing.
// Optional feature macro: LSU_MISALIGN_CHECK_EN. When it is defined,
// misaligned half/word accesses are rejected with a one-cycle lsu_misalign_o
// pulse. When it is undefined, such accesses go out with truncated lanes.
module mem_lsu (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_mtype_i,
   input  logic        ex_mem_rw_i,
   input  logic [1:0]  ex_mem_width_i,
   input  logic [31:0] ex_mem_addr_i,
   input  logic [31:0] ex_mem_wr_data_i,
   input  logic        ex_mem_rdtype_i,
   input  logic [31:0] ex_alu_res_i,
   input  logic [4:0]  ex_reg_waddr_i,
   input  logic        ex_reg_we_i,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [3:0]  bus_be_o,
   output logic [31:0] bus_wdata_o,
   input  logic        bus_ack_i,
   input  logic [31:0] bus_rdata_i,
   output logic        lsu_stall_o,
   output logic [31:0] mem_wb_reg_wdata_o,
   output logic [4:0]  mem_wb_reg_waddr_o,
   output logic        mem_wb_reg_we_o,
   output logic        lsu_misalign_o
);

   typedef enum logic {IDLE, BUS} state_t;

   state_t      state;
   logic [1:0]  cap_off;
   logic [1:0]  cap_width;
   logic        cap_rw;
   logic        cap_rdtype;
   logic [4:0]  cap_waddr;
   logic        cap_we;

   logic        misaligned;
   logic [3:0]  st_be;
   logic [31:0] st_wdata;
   logic [31:0] ld_shifted;
   logic [31:0] ld_data;

`ifdef LSU_MISALIGN_CHECK_EN
   assign misaligned = ((ex_mem_width_i == 2'b01) & ex_mem_addr_i[0]) |
                       (ex_mem_width_i[1] & (ex_mem_addr_i[1:0] != 2'b00));
`else
   assign misaligned = 1'b0;
`endif

   // Stall while an accepted access is waiting to issue or while the bus is busy; never in reset
   assign lsu_stall_o = ~rst & (((state == IDLE) & ex_mtype_i & ~misaligned) |
                                ((state == BUS) & ~bus_ack_i));

   // Byte enables and lane-replicated write data for the op currently in EX
   always_comb begin
      st_be    = 4'b1111;
      st_wdata = ex_mem_wr_data_i;
      case (ex_mem_width_i)
         2'b00: begin
            st_be    = 4'b0001 << ex_mem_addr_i[1:0];
            st_wdata = {4{ex_mem_wr_data_i[7:0]}};
         end
         2'b01: begin
            st_be    = 4'b0011 << {ex_mem_addr_i[1], 1'b0};
            st_wdata = {2{ex_mem_wr_data_i[15:0]}};
         end
         default: begin
            st_be    = 4'b1111;
            st_wdata = ex_mem_wr_data_i;
         end
      endcase
   end

   // Right-align the read word by the captured byte offset, then zero/sign extend
   always_comb begin
      ld_shifted = bus_rdata_i >> {cap_off, 3'b000};
      ld_data    = ld_shifted;
      case (cap_width)
         2'b00:   ld_data = cap_rdtype ? {24'h0, ld_shifted[7:0]}
                                       : {{24{ld_shifted[7]}}, ld_shifted[7:0]};
         2'b01:   ld_data = cap_rdtype ? {16'h0, ld_shifted[15:0]}
                                       : {{16{ld_shifted[15]}}, ld_shifted[15:0]};
         default: ld_data = ld_shifted;
      endcase
   end

   // Main FSM: pass-through writeback in IDLE, capture and hold the bus access in BUS
   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= IDLE;
         bus_req_o          <= 1'b0;
         bus_we_o           <= 1'b0;
         bus_addr_o         <= 32'h0;
         bus_be_o           <= 4'h0;
         bus_wdata_o        <= 32'h0;
         mem_wb_reg_wdata_o <= 32'h0;
         mem_wb_reg_waddr_o <= 5'h0;
         mem_wb_reg_we_o    <= 1'b0;
         cap_off            <= 2'b00;
         cap_width          <= 2'b00;
         cap_rw             <= 1'b0;
         cap_rdtype         <= 1'b0;
         cap_waddr          <= 5'h0;
         cap_we             <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!ex_mtype_i) begin
                  mem_wb_reg_wdata_o <= ex_alu_res_i;
                  mem_wb_reg_waddr_o <= ex_reg_waddr_i;
                  mem_wb_reg_we_o    <= ex_reg_we_i;
               end else if (misaligned) begin
                  mem_wb_reg_we_o <= 1'b0;
               end else begin
                  state           <= BUS;
                  bus_req_o       <= 1'b1;
                  bus_we_o        <= ex_mem_rw_i;
                  bus_addr_o      <= {ex_mem_addr_i[31:2], 2'b00};
                  bus_be_o        <= st_be;
                  bus_wdata_o     <= st_wdata;
                  cap_off         <= ex_mem_addr_i[1:0];
                  cap_width       <= ex_mem_width_i;
                  cap_rw          <= ex_mem_rw_i;
                  cap_rdtype      <= ex_mem_rdtype_i;
                  cap_waddr       <= ex_reg_waddr_i;
                  cap_we          <= ex_reg_we_i;
                  mem_wb_reg_we_o <= 1'b0;
               end
            end
            BUS: begin
               if (bus_ack_i) begin
                  state              <= IDLE;
                  bus_req_o          <= 1'b0;
                  bus_we_o           <= 1'b0;
                  bus_addr_o         <= 32'h0;
                  bus_be_o           <= 4'h0;
                  bus_wdata_o        <= 32'h0;
                  mem_wb_reg_wdata_o <= ld_data;
                  mem_wb_reg_waddr_o <= cap_waddr;
                  mem_wb_reg_we_o    <= cap_we & ~cap_rw;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef LSU_MISALIGN_CHECK_EN
   logic misalign_q;

   // One-cycle pulse for a rejected misaligned access seen in IDLE
   always_ff @(posedge clk) begin
      if (rst) misalign_q <= 1'b0;
      else     misalign_q <= (state == IDLE) & ex_mtype_i & misaligned;
   end

   assign lsu_misalign_o = misalign_q;
`else
   assign lsu_misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed self-checking bench for mem_lsu.
// Covers pass-through writeback, load extension, store lanes, a delayed ack,
// reset during a bus access and misaligned handling. The misaligned checks
// follow LSU_MISALIGN_CHECK_EN when it is defined.
module tb_mem_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_mtype_i, ex_mem_rw_i, ex_mem_rdtype_i, ex_reg_we_i;
   logic [1:0]  ex_mem_width_i;
   logic [31:0] ex_mem_addr_i, ex_mem_wr_data_i, ex_alu_res_i;
   logic [4:0]  ex_reg_waddr_i;
   logic        bus_req_o, bus_we_o, bus_ack_i;
   logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
   logic [3:0]  bus_be_o;
   logic        lsu_stall_o, mem_wb_reg_we_o, lsu_misalign_o;
   logic [31:0] mem_wb_reg_wdata_o;
   logic [4:0]  mem_wb_reg_waddr_o;

   int tests = 0;
   int fails = 0;

   // Load table: address, width, rdtype, raw word, expected writeback, expected be
   logic [31:0] ld_addr  [5] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h101};
   logic [1:0]  ld_width [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
   logic        ld_zext  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
   logic [31:0] ld_exp   [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80AA,
                                 32'h000055CC, 32'h00000055};
   logic [3:0]  ld_be    [5] = '{4'b1000, 4'b1000, 4'b1100, 4'b0011, 4'b0010};

   // Store table: width, address, data, expected bus address, be, wdata
   logic [1:0]  st_width [3] = '{2'b01, 2'b00, 2'b10};
   logic [31:0] st_addr  [3] = '{32'h202, 32'h201, 32'h300};
   logic [31:0] st_data  [3] = '{32'hDEADBEEF, 32'h11223344, 32'hCAFEF00D};
   logic [31:0] st_baddr [3] = '{32'h200, 32'h200, 32'h300};
   logic [3:0]  st_be    [3] = '{4'b1100, 4'b0010, 4'b1111};
   logic [31:0] st_wd    [3] = '{32'hBEEFBEEF, 32'h44444444, 32'hCAFEF00D};

   mem_lsu dut (
      .clk                (clk),
      .rst                (rst),
      .ex_mtype_i         (ex_mtype_i),
      .ex_mem_rw_i        (ex_mem_rw_i),
      .ex_mem_width_i     (ex_mem_width_i),
      .ex_mem_addr_i      (ex_mem_addr_i),
      .ex_mem_wr_data_i   (ex_mem_wr_data_i),
      .ex_mem_rdtype_i    (ex_mem_rdtype_i),
      .ex_alu_res_i       (ex_alu_res_i),
      .ex_reg_waddr_i     (ex_reg_waddr_i),
      .ex_reg_we_i        (ex_reg_we_i),
      .bus_req_o          (bus_req_o),
      .bus_we_o           (bus_we_o),
      .bus_addr_o         (bus_addr_o),
      .bus_be_o           (bus_be_o),
      .bus_wdata_o        (bus_wdata_o),
      .bus_ack_i          (bus_ack_i),
      .bus_rdata_i        (bus_rdata_i),
      .lsu_stall_o        (lsu_stall_o),
      .mem_wb_reg_wdata_o (mem_wb_reg_wdata_o),
      .mem_wb_reg_waddr_o (mem_wb_reg_waddr_o),
      .mem_wb_reg_we_o    (mem_wb_reg_we_o),
      .lsu_misalign_o     (lsu_misalign_o)
   );

   // 100 MHz free-running clock
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 time unit past it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a memory op on the EX inputs
   task automatic applyStimulus(input logic rw, input logic [1:0] width, input logic [31:0] addr,
                                input logic [31:0] data, input logic zext, input logic [4:0] waddr);
      ex_mtype_i       = 1'b1;
      ex_mem_rw_i      = rw;
      ex_mem_width_i   = width;
      ex_mem_addr_i    = addr;
      ex_mem_wr_data_i = data;
      ex_mem_rdtype_i  = zext;
      ex_reg_waddr_i   = waddr;
      ex_reg_we_i      = 1'b1;
      ex_alu_res_i     = 32'h0;
   endtask

   task automatic test_reset();
      rst = 1'b1; ex_mtype_i = 1'b1; ex_mem_rw_i = 1'b0; ex_mem_width_i = 2'b10;
      ex_mem_addr_i = 32'h0; ex_mem_wr_data_i = 32'h0; ex_mem_rdtype_i = 1'b0;
      ex_alu_res_i = 32'h0; ex_reg_waddr_i = 5'h0; ex_reg_we_i = 1'b0;
      bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
      tick(); tick();
      tests++; if (lsu_stall_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_stall got %b want 0", lsu_stall_o); end
      tests++; if (bus_req_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_req got %b want 0", bus_req_o); end
      tests++; if (bus_be_o !== 4'h0) begin fails++; $display("[TB] FAIL reset_be got %b want 0000", bus_be_o); end
      tests++; if (mem_wb_reg_we_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_wb_we got %b want 0", mem_wb_reg_we_o); end
      tests++; if (mem_wb_reg_wdata_o !== 32'h0) begin fails++; $display("[TB] FAIL reset_wb_wdata got %h want 0", mem_wb_reg_wdata_o); end
      tests++; if (lsu_misalign_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_misalign got %b want 0", lsu_misalign_o); end
      rst = 1'b0; ex_mtype_i = 1'b0;
      tick();
   endtask

   task automatic test_alu_passthrough();
      ex_mtype_i = 1'b0; ex_alu_res_i = 32'h12345678; ex_reg_waddr_i = 5'd5; ex_reg_we_i = 1'b1;
      #1;
      tests++; if (lsu_stall_o !== 1'b0) begin fails++; $display("[TB] FAIL alu_stall got %b want 0", lsu_stall_o); end
      tick();
      tests++; if (mem_wb_reg_wdata_o !== 32'h12345678) begin fails++; $display("[TB] FAIL alu_wdata got %h want 12345678", mem_wb_reg_wdata_o); end
      tests++; if (mem_wb_reg_waddr_o !== 5'd5) begin fails++; $display("[TB] FAIL alu_waddr got %0d want 5", mem_wb_reg_waddr_o); end
      tests++; if (mem_wb_reg_we_o !== 1'b1) begin fails++; $display("[TB] FAIL alu_we got %b want 1", mem_wb_reg_we_o); end
   endtask

   task automatic test_loads();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, ld_width[i], ld_addr[i], 32'h0, ld_zext[i], 5'd7);
         #1;
         tests++; if (lsu_stall_o !== 1'b1) begin fails++; $display("[TB] FAIL ld%0d_accept_stall got %b want 1", i, lsu_stall_o); end
         tick();
         ex_mtype_i = 1'b0; ex_mem_addr_i = 32'hFFFFFFFF;
         tests++; if (bus_req_o !== 1'b1) begin fails++; $display("[TB] FAIL ld%0d_req got %b want 1", i, bus_req_o); end
         tests++; if (bus_addr_o !== 32'h100) begin fails++; $display("[TB] FAIL ld%0d_addr got %h want 00000100", i, bus_addr_o); end
         tests++; if (bus_be_o !== ld_be[i]) begin fails++; $display("[TB] FAIL ld%0d_be got %b want %b", i, bus_be_o, ld_be[i]); end
         tests++; if (bus_we_o !== 1'b0) begin fails++; $display("[TB] FAIL ld%0d_we got %b want 0", i, bus_we_o); end
         tests++; if (mem_wb_reg_we_o !== 1'b0) begin fails++; $display("[TB] FAIL ld%0d_bubble got %b want 0", i, mem_wb_reg_we_o); end
         bus_ack_i = 1'b1; bus_rdata_i = 32'h80AA55CC;
         #1;
         tests++; if (lsu_stall_o !== 1'b0) begin fails++; $display("[TB] FAIL ld%0d_ack_stall got %b want 0", i, lsu_stall_o); end
         tick();
         bus_ack_i = 1'b0;
         tests++; if (mem_wb_reg_wdata_o !== ld_exp[i]) begin fails++; $display("[TB] FAIL ld%0d_data got %h want %h", i, mem_wb_reg_wdata_o, ld_exp[i]); end
         tests++; if (mem_wb_reg_waddr_o !== 5'd7) begin fails++; $display("[TB] FAIL ld%0d_waddr got %0d want 7", i, mem_wb_reg_waddr_o); end
         tests++; if (mem_wb_reg_we_o !== 1'b1) begin fails++; $display("[TB] FAIL ld%0d_wb_we got %b want 1", i, mem_wb_reg_we_o); end
         tests++; if (bus_req_o !== 1'b0) begin fails++; $display("[TB] FAIL ld%0d_req_drop got %b want 0", i, bus_req_o); end
      end
   endtask

   task automatic test_stores();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, st_width[i], st_addr[i], st_data[i], 1'b0, 5'd3);
         tick();
         ex_mtype_i = 1'b0;
         tests++; if (bus_req_o !== 1'b1) begin fails++; $display("[TB] FAIL st%0d_req got %b want 1", i, bus_req_o); end
         tests++; if (bus_addr_o !== st_baddr[i]) begin fails++; $display("[TB] FAIL st%0d_addr got %h want %h", i, bus_addr_o, st_baddr[i]); end
         tests++; if (bus_be_o !== st_be[i]) begin fails++; $display("[TB] FAIL st%0d_be got %b want %b", i, bus_be_o, st_be[i]); end
         tests++; if (bus_wdata_o !== st_wd[i]) begin fails++; $display("[TB] FAIL st%0d_wdata got %h want %h", i, bus_wdata_o, st_wd[i]); end
         tests++; if (bus_we_o !== 1'b1) begin fails++; $display("[TB] FAIL st%0d_we got %b want 1", i, bus_we_o); end
         bus_ack_i = 1'b1;
         tick();
         bus_ack_i = 1'b0;
         tests++; if (mem_wb_reg_we_o !== 1'b0) begin fails++; $display("[TB] FAIL st%0d_wb_we got %b want 0", i, mem_wb_reg_we_o); end
         tests++; if (bus_req_o !== 1'b0) begin fails++; $display("[TB] FAIL st%0d_req_drop got %b want 0", i, bus_req_o); end
      end
   endtask

   task automatic test_back_to_back();
      applyStimulus(1'b0, 2'b10, 32'h400, 32'h0, 1'b0, 5'd9);
      tick();
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 2'b00, 32'h999, 32'h55555555, 1'b1, 5'd1);
         #1;
         tests++; if (bus_req_o !== 1'b1) begin fails++; $display("[TB] FAIL wait%0d_req got %b want 1", k, bus_req_o); end
         tests++; if (bus_addr_o !== 32'h400) begin fails++; $display("[TB] FAIL wait%0d_addr got %h want 00000400", k, bus_addr_o); end
         tests++; if (bus_be_o !== 4'b1111 || bus_we_o !== 1'b0) begin fails++; $display("[TB] FAIL wait%0d_be_we got %b/%b want 1111/0", k, bus_be_o, bus_we_o); end
         tests++; if (lsu_stall_o !== 1'b1) begin fails++; $display("[TB] FAIL wait%0d_stall got %b want 1", k, lsu_stall_o); end
         tick();
      end
      ex_mtype_i = 1'b0; ex_alu_res_i = 32'h0000A5A5; ex_reg_waddr_i = 5'd2; ex_reg_we_i = 1'b1;
      bus_ack_i = 1'b1; bus_rdata_i = 32'h13579BDF;
      #1;
      tests++; if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h400) begin fails++; $display("[TB] FAIL ackcyc_req_addr got %b/%h want 1/00000400", bus_req_o, bus_addr_o); end
      tests++; if (lsu_stall_o !== 1'b0) begin fails++; $display("[TB] FAIL ackcyc_stall got %b want 0", lsu_stall_o); end
      tests++; if (mem_wb_reg_we_o !== 1'b0) begin fails++; $display("[TB] FAIL ackcyc_wb_early got %b want 0", mem_wb_reg_we_o); end
      tick();
      bus_ack_i = 1'b0;
      tests++; if (mem_wb_reg_wdata_o !== 32'h13579BDF) begin fails++; $display("[TB] FAIL lw_data got %h want 13579bdf", mem_wb_reg_wdata_o); end
      tests++; if (mem_wb_reg_waddr_o !== 5'd9 || mem_wb_reg_we_o !== 1'b1) begin fails++; $display("[TB] FAIL lw_waddr_we got %0d/%b want 9/1", mem_wb_reg_waddr_o, mem_wb_reg_we_o); end
      tick();
      tests++; if (mem_wb_reg_wdata_o !== 32'h0000A5A5 || mem_wb_reg_waddr_o !== 5'd2) begin fails++; $display("[TB] FAIL follow_alu got %h/%0d want 0000a5a5/2", mem_wb_reg_wdata_o, mem_wb_reg_waddr_o); end
   endtask

   task automatic test_reset_in_bus();
      applyStimulus(1'b0, 2'b10, 32'h500, 32'h0, 1'b0, 5'd4);
      tick();
      tests++; if (bus_req_o !== 1'b1) begin fails++; $display("[TB] FAIL rbus_req_before got %b want 1", bus_req_o); end
      rst = 1'b1; ex_mtype_i = 1'b0; ex_reg_we_i = 1'b0; ex_alu_res_i = 32'h0; ex_reg_waddr_i = 5'd0;
      tick();
      tests++; if (bus_req_o !== 1'b0 || bus_addr_o !== 32'h0) begin fails++; $display("[TB] FAIL rbus_req_addr got %b/%h want 0/00000000", bus_req_o, bus_addr_o); end
      tests++; if (lsu_stall_o !== 1'b0) begin fails++; $display("[TB] FAIL rbus_stall_in_rst got %b want 0", lsu_stall_o); end
      rst = 1'b0;
      #1;
      tests++; if (lsu_stall_o !== 1'b0) begin fails++; $display("[TB] FAIL rbus_idle_stall got %b want 0", lsu_stall_o); end
      bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFFFFFF;
      tick();
      bus_ack_i = 1'b0;
      tests++; if (mem_wb_reg_we_o !== 1'b0 || mem_wb_reg_wdata_o !== 32'h0) begin fails++; $display("[TB] FAIL rbus_late_ack got %b/%h want 0/00000000", mem_wb_reg_we_o, mem_wb_reg_wdata_o); end
      tests++; if (bus_req_o !== 1'b0) begin fails++; $display("[TB] FAIL rbus_req_after got %b want 0", bus_req_o); end
   endtask

   task automatic test_misalign();
      applyStimulus(1'b0, 2'b10, 32'h101, 32'h0, 1'b0, 5'd6);
      #1;
`ifdef LSU_MISALIGN_CHECK_EN
      tests++; if (lsu_stall_o !== 1'b0) begin fails++; $display("[TB] FAIL mis_stall got %b want 0", lsu_stall_o); end
      tick();
      ex_mtype_i = 1'b0; ex_reg_we_i = 1'b0;
      tests++; if (bus_req_o !== 1'b0) begin fails++; $display("[TB] FAIL mis_req got %b want 0", bus_req_o); end
      tests++; if (lsu_misalign_o !== 1'b1) begin fails++; $display("[TB] FAIL mis_pulse got %b want 1", lsu_misalign_o); end
      tests++; if (mem_wb_reg_we_o !== 1'b0) begin fails++; $display("[TB] FAIL mis_wb_we got %b want 0", mem_wb_reg_we_o); end
      tick();
      tests++; if (lsu_misalign_o !== 1'b0 || bus_req_o !== 1'b0) begin fails++; $display("[TB] FAIL mis_pulse_end got %b/%b want 0/0", lsu_misalign_o, bus_req_o); end
`else
      tests++; if (lsu_stall_o !== 1'b1) begin fails++; $display("[TB] FAIL mis_stall got %b want 1", lsu_stall_o); end
      tick();
      ex_mtype_i = 1'b0;
      tests++; if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h100) begin fails++; $display("[TB] FAIL mis_req_addr got %b/%h want 1/00000100", bus_req_o, bus_addr_o); end
      tests++; if (bus_be_o !== 4'b1111) begin fails++; $display("[TB] FAIL mis_be got %b want 1111", bus_be_o); end
      tests++; if (lsu_misalign_o !== 1'b0) begin fails++; $display("[TB] FAIL mis_flag got %b want 0", lsu_misalign_o); end
      bus_ack_i = 1'b1; bus_rdata_i = 32'h44332211;
      tick();
      bus_ack_i = 1'b0;
      tests++; if (mem_wb_reg_wdata_o !== 32'h00443322 || mem_wb_reg_we_o !== 1'b1) begin fails++; $display("[TB] FAIL mis_data got %h/%b want 00443322/1", mem_wb_reg_wdata_o, mem_wb_reg_we_o); end
`endif
   endtask

   // Run every scenario in order, then report
   initial begin
      test_reset();
      test_alu_passthrough();
      test_loads();
      test_stores();
      test_back_to_back();
      test_reset_in_bus();
      test_misalign();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port ex_mtype_i  input  1  current EX-stage op is a memory access.
REQ-004 SHALL have port ex_mem_rw_i  input  1  1 = store, 0 = load.
REQ-005 SHALL have port ex_mem_width_i  input  2  00 byte, 01 half, 10/11 word.
REQ-006 SHALL have port ex_mem_addr_i  input  32  byte address (ALU result).
REQ-007 SHALL have port ex_mem_wr_data_i  input  32  store data, right-aligned.
REQ-008 SHALL have port ex_mem_rdtype_i  input  1  load extension: 1 = zero, 0 = sign.
REQ-009 SHALL have port ex_alu_res_i  input  32  writeback value for non-memory ops.
REQ-010 SHALL have port ex_reg_waddr_i  input  5  destination register.
REQ-011 SHALL have port ex_reg_we_i  input  1  destination write enable.
REQ-012 SHALL have port bus_req_o  output  1  data-bus request, held until ack.
REQ-013 SHALL have port bus_we_o  output  1  bus write strobe.
REQ-014 SHALL have port bus_addr_o  output  32  word-aligned address {addr[31:2],2'b00}.
REQ-015 SHALL have port bus_be_o  output  4  byte enables.
REQ-016 SHALL have port bus_wdata_o  output  32  lane-replicated store data.
REQ-017 SHALL have port bus_ack_i  input  1  transfer complete; rdata valid same cycle.
REQ-018 SHALL have port bus_rdata_i  input  32  raw read word.
REQ-019 SHALL have port lsu_stall_o  output  1  combinational; upstream holds EX inputs while 1.
REQ-020 SHALL have ports mem_wb_reg_wdata_o/waddr_o/we_o  output  32/5/1  registered writeback.
REQ-021 SHALL have port lsu_misalign_o  output  1  one-cycle misaligned-access pulse.

Function
REQ-022 SHALL implement FSM states IDLE and BUS.
REQ-023 IDLE, ex_mtype_i=0: next edge wb outputs <= ex_alu_res_i/ex_reg_waddr_i/ex_reg_we_i; stall 0 (latency 1).
REQ-024 IDLE, ex_mtype_i=1, aligned: capture op, go BUS; mem_wb_reg_we_o <= 0 (bubble).
REQ-025 lsu_stall_o SHALL equal (IDLE & ex_mtype_i & aligned) | (BUS & ~bus_ack_i).
REQ-026 In BUS, bus_req_o=1 with addr/be/wdata/we stable from captured values until the ack cycle.
REQ-027 On BUS & bus_ack_i: next edge go IDLE, bus_req_o 0, wb outputs loaded; store forces we=0.
REQ-028 Store lanes: byte be=0001<<addr[1:0], wdata={4{d[7:0]}}; half be=0011<<{addr[1],0}, wdata={2{d[15:0]}}; word be=1111.
REQ-029 Load: data = rdata >> 8*addr[1:0], then zero/sign extend per width and rdtype; word unextended.
REQ-030 Loads SHALL drive bus_be_o per REQ-028 and bus_we_o=0.
REQ-031 Minimum load/store latency: accept T, req T+1, ack T+1, wb valid after T+2 edge.
REQ-032 While in BUS, EX inputs SHALL be ignored.

Reset
REQ-033 On rst: state IDLE; all outputs 0 at next edge; in-flight request dropped without waiting for ack.
REQ-034 lsu_stall_o SHALL be 0 during reset.

Configuration
REQ-035 Macro LSU_MISALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 is not issued; lsu_misalign_o pulses 1 cycle, wb we=0, stall 0, stays IDLE.
REQ-036 Macro undefined: no check; lsu_misalign_o tied 0; access issued with bus_be_o per REQ-028 (lanes may wrap/truncate).

Verification
REQ-037 Non-mem op alu_res=0x12345678, waddr=5, we=1 -> next cycle wdata=0x12345678, waddr=5, we=1, stall 0.
REQ-038 lb addr=0x103, rdata=0x80AA55CC, ack same cycle as req -> wdata=0xFFFFFF80; lbu -> 0x00000080.
REQ-039 sh addr=0x202 data=0xDEADBEEF -> bus_addr=0x200, be=1100, wdata=0xBEEFBEEF, we=1; wb we=0.
REQ-040 lw with ack delayed 3 cycles -> req/addr stable 4 cycles, stall high until ack cycle, wb one edge after ack.
REQ-041 rst asserted in BUS -> next edge bus_req_o=0, IDLE, outputs 0; later ack ignored.
REQ-042 With LSU_MISALIGN_CHECK_EN, lw addr=0x101 -> no bus_req, lsu_misalign_o=1 for one cycle, wb we=0.
